dac_spi_transmitter: RTL and testbench

DAC_SPI_TRANSMITTER -- requirements
Module: dac_spi_transmitter

---
 rtl/dac_spi_transmitter.sv | 157 +++++++++++++++
 tb/tb_dac_spi_transmitter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_transmitter.sv
// dac_spi_transmitter: serialises 24-bit samples MSB first over an SPI-style
// link (sclk idles low, data launched while sclk is low) with a minimum
// cs_n gap between frames and a one-entry pending buffer for early ticks.
// Optional feature: define DAC_OFFSET_BINARY_EN to send offset-binary words
// (bit 23 inverted) instead of two's complement.
module dac_spi_transmitter #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic [23:0] data_i,
    output logic        sclk_o,
    output logic        sdata_o,
    output logic        cs_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        dropped_o,
    output logic [15:0] drop_count_o
);

    localparam int unsigned BIT_CYC = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX = (BIT_CYC > CS_GAP) ? (BIT_CYC - 1) : (CS_GAP - 1);
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [4:0]         bit_idx, bit_n;
    logic [23:0]        shreg, shreg_n;
    logic [23:0]        pend, pend_n;
    logic               pend_vld, pend_vld_n;
    logic [15:0]        drop_cnt_n;
    logic               sclk_n, sdata_n, cs_n_n, busy_n, done_n;
    logic               last_bit_cyc, last_gap, consume;

    // Word as it goes on the wire.
    function automatic logic [23:0] to_wire(input logic [23:0] d);
`ifdef DAC_OFFSET_BINARY_EN
        return {~d[23], d[22:0]};
`else
        return d;
`endif
    endfunction

    // Next-state, pending-buffer and next-output decode.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_n      = bit_idx;
        shreg_n    = shreg;
        pend_n     = pend;
        pend_vld_n = pend_vld;
        drop_cnt_n = drop_count_o;
        dropped_o  = 1'b0;

        last_bit_cyc = (cnt == CNT_W'(BIT_CYC - 1));
        last_gap     = (cnt == CNT_W'(CS_GAP - 1));
        consume      = (state == GAP) && last_gap;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (tick_i) begin
                    state_n = SHIFT;
                    shreg_n = to_wire(data_i);
                    bit_n   = '0;
                end
            end
            SHIFT: begin
                if (last_bit_cyc) begin
                    cnt_n   = '0;
                    shreg_n = {shreg[22:0], 1'b0};
                    if (bit_idx == 5'd23) begin
                        state_n = GAP;
                    end else begin
                        bit_n = bit_idx + 5'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (last_gap) begin
                    cnt_n = '0;
                    bit_n = '0;
                    if (pend_vld) begin
                        state_n    = SHIFT;
                        shreg_n    = to_wire(pend);
                        pend_vld_n = 1'b0;
                    end else if (tick_i) begin
                        state_n = SHIFT;
                        shreg_n = to_wire(data_i);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Ticks while busy land in the pending slot; a tick that goes straight
        // into a new frame at the end of the gap does not.
        if (tick_i && (state != IDLE) && !(consume && !pend_vld)) begin
            pend_n     = data_i;
            pend_vld_n = 1'b1;
            if (pend_vld && !consume) begin
                dropped_o = 1'b1;
                if (drop_count_o != 16'hFFFF) begin
                    drop_cnt_n = drop_count_o + 16'd1;
                end
            end
        end

        sclk_n  = (state_n == SHIFT) && (cnt_n >= CNT_W'(CLK_DIV));
        sdata_n = (state_n == SHIFT) && shreg_n[23];
        cs_n_n  = (state_n != SHIFT);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == GAP) && (cnt_n == CNT_W'(CS_GAP - 1));
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            pend         <= '0;
            pend_vld     <= 1'b0;
            drop_count_o <= '0;
            sclk_o       <= 1'b0;
            sdata_o      <= 1'b0;
            cs_n_o       <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_n;
            shreg        <= shreg_n;
            pend         <= pend_n;
            pend_vld     <= pend_vld_n;
            drop_count_o <= drop_cnt_n;
            sclk_o       <= sclk_n;
            sdata_o      <= sdata_n;
            cs_n_o       <= cs_n_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
        end
    end

endmodule

// File: tb/tb_dac_spi_transmitter.sv
// Directed bench for dac_spi_transmitter (CLK_DIV=2, CS_GAP=4).
module tb_dac_spi_transmitter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        tick_i;
    logic [23:0] data_i;
    logic        sclk_o, sdata_o, cs_n_o, busy_o, done_o, dropped_o;
    logic [15:0] drop_count_o;

    int vectors = 0;
    int miscompares = 0;

    logic        cs_h   [0:511];
    logic        sclk_h [0:511];
    logic        sdata_h[0:511];
    logic        done_h [0:511];
    logic        drop_h [0:511];
    logic        busy_h [0:511];
    logic [15:0] dcnt_h [0:511];
    logic [23:0] words[$];
    int          tick_at[$];
    logic [23:0] tick_dat[$];
    int          rst_at;

    dac_spi_transmitter #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .data_i(data_i),
        .sclk_o(sclk_o), .sdata_o(sdata_o), .cs_n_o(cs_n_o), .busy_o(busy_o),
        .done_o(done_o), .dropped_o(dropped_o), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] wire_of(input logic [23:0] d);
`ifdef DAC_OFFSET_BINARY_EN
        return d ^ 24'h800000;
`else
        return d;
`endif
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        tick_i  = 1'b0;
        data_i  = '0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        tick_at.delete();
        tick_dat.delete();
        rst_at = -1;
    endtask

    // Drives the tick/reset schedule for ncyc cycles (k = 0 is T) and records outputs.
    task automatic run_window(input int ncyc);
        logic pcs, psclk;
        logic [23:0] cap;
        int bits;
        pcs = cs_n_o; psclk = sclk_o; cap = '0; bits = 0;
        words.delete();
        for (int k = 0; k < ncyc; k++) begin
            tick_i = 1'b0;
            data_i = '0;
            foreach (tick_at[i]) if (tick_at[i] == k) begin
                tick_i = 1'b1;
                data_i = tick_dat[i];
            end
            reset_i = (k == rst_at);
            #1;
            cs_h[k] = cs_n_o;  sclk_h[k] = sclk_o; sdata_h[k] = sdata_o;
            done_h[k] = done_o; drop_h[k] = dropped_o; busy_h[k] = busy_o;
            dcnt_h[k] = drop_count_o;
            if (pcs && !cs_n_o) begin bits = 0; cap = '0; end
            if (!psclk && sclk_o && !cs_n_o) begin cap = {cap[22:0], sdata_o}; bits++; end
            if (!pcs && cs_n_o && bits == 24) words.push_back(cap);
            pcs = cs_n_o; psclk = sclk_o;
            @(posedge clk);
            #1;
        end
        tick_i = 1'b0;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick_i = 1'b1; data_i = 24'h123456;
        @(posedge clk); #1;
        tick_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        tick_i = 1'b0;
        #1;
        vectors++; if (cs_n_o !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n_o); end
        vectors++; if (sclk_o !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b want 0", sclk_o); end
        vectors++; if (sdata_o !== 1'b0) begin miscompares++; $display("FAIL reset_sdata: got %b want 0", sdata_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_o); end
        vectors++; if (dropped_o !== 1'b0) begin miscompares++; $display("FAIL reset_dropped: got %b want 0", dropped_o); end
        vectors++; if (drop_count_o !== 16'd0) begin miscompares++; $display("FAIL reset_drop_count: got %h want 0000", drop_count_o); end
    endtask

    task automatic test_single_frame();
        logic exp, rise, exp_rise;
        do_reset();
        tick_at.push_back(0); tick_dat.push_back(24'h800001);
        run_window(110);
        for (int k = 0; k < 110; k++) begin
            exp = !(k >= 1 && k <= 96);
            vectors++; if (cs_h[k] !== exp) begin miscompares++; $display("FAIL single_cs_n T+%0d: got %b want %b", k, cs_h[k], exp); end
            rise = (k > 0) && !sclk_h[k-1] && sclk_h[k];
            exp_rise = (k >= 3) && (k <= 95) && ((k - 3) % 4 == 0);
            vectors++; if (rise !== exp_rise) begin miscompares++; $display("FAIL single_sclk_rise T+%0d: got %b want %b", k, rise, exp_rise); end
            exp = (k == 100);
            vectors++; if (done_h[k] !== exp) begin miscompares++; $display("FAIL single_done T+%0d: got %b want %b", k, done_h[k], exp); end
            exp = (k >= 1 && k <= 100);
            vectors++; if (busy_h[k] !== exp) begin miscompares++; $display("FAIL single_busy T+%0d: got %b want %b", k, busy_h[k], exp); end
            if (k > 0 && sdata_h[k] !== sdata_h[k-1]) begin
                vectors++; if (sclk_h[k] !== 1'b0) begin miscompares++; $display("FAIL single_sdata_edge T+%0d: sclk %b want 0 on data change", k, sclk_h[k]); end
            end
            if (k >= 97 && k <= 100) begin
                vectors++; if (sdata_h[k] !== 1'b0 || sclk_h[k] !== 1'b0) begin miscompares++; $display("FAIL single_gap_lines T+%0d: sdata %b sclk %b want 0 0", k, sdata_h[k], sclk_h[k]); end
            end
        end
        if (1) begin
            logic [23:0] w0;
            w0 = (words.size() > 0) ? words[0] : 24'hxxxxxx;
            vectors++;
            if (words.size() != 1 || w0 !== wire_of(24'h800001)) begin
                miscompares++; $display("FAIL single_word: got %0d words first %h want 1 word %h", words.size(), w0, wire_of(24'h800001));
            end
        end
    endtask

    // Shared frame-pair checks for the two-frame scenarios.
    task automatic test_two_frames(input string name, input int t2, input logic [23:0] d0,
                                   input logic [23:0] d1, input logic [23:0] d2, input logic [23:0] d3,
                                   input int ntick, input logic [23:0] want1);
        logic exp;
        logic [23:0] w0, w1;
        do_reset();
        tick_at.push_back(0);  tick_dat.push_back(d0);
        tick_at.push_back(t2); tick_dat.push_back(d1);
        if (ntick == 4) begin
            tick_at.push_back(20); tick_dat.push_back(d2);
            tick_at.push_back(30); tick_dat.push_back(d3);
        end
        run_window(205);
        for (int k = 0; k < 205; k++) begin
            exp = !((k >= 1 && k <= 96) || (k >= 101 && k <= 196));
            vectors++; if (cs_h[k] !== exp) begin miscompares++; $display("FAIL %s_cs_n T+%0d: got %b want %b", name, k, cs_h[k], exp); end
            exp = (ntick == 4) && (k == 20 || k == 30);
            vectors++; if (drop_h[k] !== exp) begin miscompares++; $display("FAIL %s_dropped T+%0d: got %b want %b", name, k, drop_h[k], exp); end
            exp = (k == 100 || k == 200);
            vectors++; if (done_h[k] !== exp) begin miscompares++; $display("FAIL %s_done T+%0d: got %b want %b", name, k, done_h[k], exp); end
        end
        vectors++;
        if (dcnt_h[204] !== ((ntick == 4) ? 16'd2 : 16'd0)) begin
            miscompares++; $display("FAIL %s_drop_count: got %h want %h", name, dcnt_h[204], (ntick == 4) ? 16'd2 : 16'd0);
        end
        w0 = (words.size() > 0) ? words[0] : 24'hxxxxxx;
        w1 = (words.size() > 1) ? words[1] : 24'hxxxxxx;
        vectors++;
        if (words.size() != 2 || w0 !== wire_of(d0) || w1 !== wire_of(want1)) begin
            miscompares++; $display("FAIL %s_words: got %0d words [%h %h] want 2 [%h %h]", name, words.size(), w0, w1, wire_of(d0), wire_of(want1));
        end
    endtask

    task automatic test_back_to_back();
        test_two_frames("b2b", 10, 24'h5A5A5A, 24'hC3C3C3, 24'h0, 24'h0, 2, 24'hC3C3C3);
    endtask

    task automatic test_overflow();
        test_two_frames("ovf", 5, 24'h7FFFFF, 24'h111111, 24'h222222, 24'hABCDEF, 4, 24'hABCDEF);
        for (int k = 0; k < 40; k++) begin
            logic [15:0] e;
            e = (k > 30) ? 16'd2 : (k > 20) ? 16'd1 : 16'd0;
            vectors++; if (dcnt_h[k] !== e) begin miscompares++; $display("FAIL ovf_count_step T+%0d: got %h want %h", k, dcnt_h[k], e); end
        end
    endtask

    task automatic test_tick_on_done();
        test_two_frames("donetick", 100, 24'h000F00, 24'hF0F0F0, 24'h0, 24'h0, 2, 24'hF0F0F0);
    endtask

    task automatic test_mid_reset();
        logic exp;
        logic [23:0] w0;
        do_reset();
        tick_at.push_back(0);  tick_dat.push_back(24'h3C3C3C);
        tick_at.push_back(60); tick_dat.push_back(24'h96A5C3);
        rst_at = 40;
        run_window(170);
        vectors++; if (cs_h[41] !== 1'b1) begin miscompares++; $display("FAIL mrst_cs_n: got %b want 1", cs_h[41]); end
        vectors++; if (sclk_h[41] !== 1'b0) begin miscompares++; $display("FAIL mrst_sclk: got %b want 0", sclk_h[41]); end
        vectors++; if (busy_h[41] !== 1'b0) begin miscompares++; $display("FAIL mrst_busy: got %b want 0", busy_h[41]); end
        for (int k = 0; k < 170; k++) begin
            exp = (k == 160);
            vectors++; if (done_h[k] !== exp) begin miscompares++; $display("FAIL mrst_done T+%0d: got %b want %b", k, done_h[k], exp); end
            exp = !((k >= 1 && k <= 40) || (k >= 61 && k <= 156));
            vectors++; if (cs_h[k] !== exp) begin miscompares++; $display("FAIL mrst_cs_n T+%0d: got %b want %b", k, cs_h[k], exp); end
        end
        w0 = (words.size() > 0) ? words[0] : 24'hxxxxxx;
        vectors++;
        if (words.size() != 1 || w0 !== wire_of(24'h96A5C3)) begin
            miscompares++; $display("FAIL mrst_word: got %0d words first %h want 1 word %h", words.size(), w0, wire_of(24'h96A5C3));
        end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        tick_i = 1'b1; data_i = 24'h0000AA;
        repeat (50) @(posedge clk);
        #1;
        vectors++; if (drop_count_o !== 16'd48) begin miscompares++; $display("FAIL sat_early_count: got %h want %h", drop_count_o, 16'd48); end
        n = 0;
        while (drop_count_o !== 16'hFFFF && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++; if (drop_count_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h want FFFF after %0d cycles", drop_count_o, n); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (drop_count_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h want FFFF", drop_count_o); end
        tick_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        tick_i  = 1'b0;
        data_i  = '0;
        rst_at  = -1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_tick_on_done();
        test_mid_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
